// File: rtl/zmod_rst_seq_if.sv
// zmod_rst_seq_if -- PLL lock / reset sequencing signal bundle.
//
// Groups the PLL-side and fabric-side reset signals that travel between the
// sequencer and its environment.
//   pll_locked     PLL LOCKED indication, asynchronous to the sequencer clock
//   pll_rst        PLL reset, active-high
//   rst_fast_n     clkoutx4 domain reset, active-low
//   rst_core_n     clkout domain reset, active-low
//   ready          both domain resets released and lock stable
//   lock_loss_cnt  saturating count of lock losses seen after release began
//   timeout_err    sticky lock-timeout flag
//
// master: the sequencer (drives the resets, observes lock)
// slave : the PLL/fabric side (drives lock, observes the resets)

interface zmod_rst_seq_if;
    logic       pll_locked;
    logic       pll_rst;
    logic       rst_fast_n;
    logic       rst_core_n;
    logic       ready;
    logic [7:0] lock_loss_cnt;
    logic       timeout_err;

    modport master (
        input  pll_locked,
        output pll_rst,
        output rst_fast_n,
        output rst_core_n,
        output ready,
        output lock_loss_cnt,
        output timeout_err
    );

    modport slave (
        output pll_locked,
        input  pll_rst,
        input  rst_fast_n,
        input  rst_core_n,
        input  ready,
        input  lock_loss_cnt,
        input  timeout_err
    );
endinterface

// File: rtl/zmod_rst_seq.sv
// zmod_rst_seq -- PLL reset and fabric reset sequencer.
//
// Pulses the PLL reset, waits for a stable synchronized lock, then releases
// the clkoutx4 domain reset followed (after a gap) by the clkout domain reset.
// A lock loss after release re-asserts both domain resets without resetting
// the PLL; a lock that never stabilises within the timeout re-pulses the PLL.
//
// Ports
//   clk   free-running reference clock (PLL input clock)
//   rstn  synchronous active-low reset
//   bus   zmod_rst_seq_if.master: pll_locked in; pll_rst, rst_fast_n,
//         rst_core_n, ready, lock_loss_cnt, timeout_err out (all registered)
//
// State table
//   state     | meaning
//   PLLRST    | PLL held in reset, both domains in reset
//   WAIT_LOCK | waiting for LOCK_STABLE_CYCLES consecutive lock cycles
//   REL_FAST  | fast domain released, core domain still in reset
//   RUN       | both domains released, ready

module zmod_rst_seq #(
    parameter int PLL_RST_CYCLES     = 8,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RELEASE_GAP        = 16,
    parameter int LOCK_TIMEOUT       = 65536
) (
    input  logic           clk,
    input  logic           rstn,
    zmod_rst_seq_if.master bus
);

    localparam int PH_MAX = (PLL_RST_CYCLES > RELEASE_GAP) ? PLL_RST_CYCLES : RELEASE_GAP;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int ST_W   = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [PH_W-1:0] PH_RST_LAST = PH_W'(PLL_RST_CYCLES - 1);
    localparam logic [PH_W-1:0] PH_GAP_LAST = PH_W'(RELEASE_GAP - 1);
    localparam logic [ST_W-1:0] ST_LAST     = ST_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST     = TO_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        PLLRST    = 2'd0,
        WAIT_LOCK = 2'd1,
        REL_FAST  = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic            lock_meta, locked_s;
    logic [PH_W-1:0] phase_cnt, phase_nxt;   // shared by PLLRST and REL_FAST
    logic [ST_W-1:0] stab_cnt, stab_nxt;
    logic [TO_W-1:0] tout_cnt, tout_nxt;
    logic [7:0]      loss_cnt, loss_nxt;
    logic            terr, terr_nxt;
    logic            pll_rst_q, fast_q, core_q;
    logic            stab_hit, tout_hit;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
            state     <= PLLRST;
            phase_cnt <= '0;
            stab_cnt  <= '0;
            tout_cnt  <= '0;
            loss_cnt  <= 8'd0;
            terr      <= 1'b0;
            pll_rst_q <= 1'b1;
            fast_q    <= 1'b0;
            core_q    <= 1'b0;
        end else begin
            lock_meta <= bus.pll_locked;
            locked_s  <= lock_meta;
            state     <= state_nxt;
            phase_cnt <= phase_nxt;
            stab_cnt  <= stab_nxt;
            tout_cnt  <= tout_nxt;
            loss_cnt  <= loss_nxt;
            terr      <= terr_nxt;
            // Outputs are decoded from the next state so they change on the
            // same edge as the transition, but come straight from flops.
            pll_rst_q <= (state_nxt == PLLRST);
            fast_q    <= (state_nxt == REL_FAST) || (state_nxt == RUN);
            core_q    <= (state_nxt == RUN);
        end
    end

    // Stability match is checked before the timeout so it wins a tie.
    assign stab_hit = locked_s && (stab_cnt == ST_LAST);
    assign tout_hit = (tout_cnt == TO_LAST);

    always_comb begin
        state_nxt = state;
        phase_nxt = phase_cnt;
        stab_nxt  = stab_cnt;
        tout_nxt  = tout_cnt;
        loss_nxt  = loss_cnt;
        terr_nxt  = terr;

        case (state)
            PLLRST: begin
                if (phase_cnt == PH_RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                    phase_nxt = '0;
                    stab_nxt  = '0;
                    tout_nxt  = '0;
                end else begin
                    phase_nxt = phase_cnt + PH_W'(1);
                end
            end

            WAIT_LOCK: begin
                if (stab_hit) begin
                    state_nxt = REL_FAST;
                    phase_nxt = '0;
                end else if (tout_hit) begin
                    state_nxt = PLLRST;
                    phase_nxt = '0;
                    terr_nxt  = 1'b1;
                end else begin
                    tout_nxt = tout_cnt + TO_W'(1);
                    stab_nxt = locked_s ? stab_cnt + ST_W'(1) : '0;
                end
            end

            REL_FAST, RUN: begin
                // Lock loss outranks the REL_FAST->RUN step so the core
                // domain never sees a release while lock is gone.
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    stab_nxt  = '0;
                    tout_nxt  = '0;
                    if (loss_cnt != 8'hFF) begin
                        loss_nxt = loss_cnt + 8'd1;
                    end
                end else if (state == REL_FAST) begin
                    if (phase_cnt == PH_GAP_LAST) begin
                        state_nxt = RUN;
                    end else begin
                        phase_nxt = phase_cnt + PH_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = PLLRST;
                phase_nxt = '0;
            end
        endcase
    end

    assign bus.pll_rst       = pll_rst_q;
    assign bus.rst_fast_n    = fast_q;
    assign bus.rst_core_n    = core_q;
    assign bus.ready         = core_q;
    assign bus.lock_loss_cnt = loss_cnt;
    assign bus.timeout_err   = terr;

endmodule

// File: tb/tb_zmod_rst_seq.sv
// tb_zmod_rst_seq -- scoreboard bench for zmod_rst_seq.
//
// A timestamp-based reference model runs at every rising edge and queues the
// outputs it expects; an independent monitor pops and compares them on the
// falling edge, along with the reset-ordering invariants.

module tb_zmod_rst_seq;
    localparam int PRC = 3;
    localparam int LSC = 8;
    localparam int RG  = 4;
    localparam int LT  = 64;

    localparam int M_PLLRST = 0;
    localparam int M_WAIT   = 1;
    localparam int M_GAP    = 2;
    localparam int M_RUN    = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    zmod_rst_seq_if bus ();

    zmod_rst_seq #(
        .PLL_RST_CYCLES     (PRC),
        .LOCK_STABLE_CYCLES (LSC),
        .RELEASE_GAP        (RG),
        .LOCK_TIMEOUT       (LT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pll_rst;
        logic       rst_fast_n;
        logic       rst_core_n;
        logic       ready;
        logic [7:0] loss;
        logic       terr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: each phase is remembered by the edge it started on.
    int   edge_n = 0;
    int   m_mode = M_PLLRST;
    int   t0     = 0;
    int   quiet  = 0;   // last edge in WAIT with no synchronized lock
    int   losses = 0;
    bit   terr   = 1'b0;
    logic p1     = 1'b0;
    logic p2     = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", nm, act, req, edge_n, $time);
        end
    endtask

    task automatic model_edge();
        logic ls;
        exp_t e;
        edge_n++;
        if (!rstn) begin
            m_mode = M_PLLRST;
            t0     = edge_n;
            losses = 0;
            terr   = 1'b0;
            p1     = 1'b0;
            p2     = 1'b0;
        end else begin
            ls = p2;
            p2 = p1;
            p1 = bus.pll_locked;
            case (m_mode)
                M_PLLRST: begin
                    if (edge_n - t0 >= PRC) begin
                        m_mode = M_WAIT;
                        t0     = edge_n;
                        quiet  = edge_n;
                    end
                end
                M_WAIT: begin
                    if (!ls) quiet = edge_n;
                    if (edge_n - quiet >= LSC) begin
                        m_mode = M_GAP;
                        t0     = edge_n;
                    end else if (edge_n - t0 >= LT) begin
                        m_mode = M_PLLRST;
                        t0     = edge_n;
                        terr   = 1'b1;
                    end
                end
                default: begin
                    if (!ls) begin
                        m_mode = M_WAIT;
                        t0     = edge_n;
                        quiet  = edge_n;
                        if (losses < 255) losses++;
                    end else if (m_mode == M_GAP && edge_n - t0 >= RG) begin
                        m_mode = M_RUN;
                    end
                end
            endcase
        end
        e.pll_rst    = (m_mode == M_PLLRST);
        e.rst_fast_n = (m_mode == M_GAP) || (m_mode == M_RUN);
        e.rst_core_n = (m_mode == M_RUN);
        e.ready      = (m_mode == M_RUN);
        e.loss       = 8'(losses);
        e.terr       = terr;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) model_edge();

    exp_t got_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            got_e = exp_q.pop_front();
            chk("pll_rst",       bus.pll_rst,       got_e.pll_rst);
            chk("rst_fast_n",    bus.rst_fast_n,    got_e.rst_fast_n);
            chk("rst_core_n",    bus.rst_core_n,    got_e.rst_core_n);
            chk("ready",         bus.ready,         got_e.ready);
            chk("lock_loss_cnt", bus.lock_loss_cnt, got_e.loss);
            chk("timeout_err",   bus.timeout_err,   got_e.terr);
            chk("inv_core_implies_fast", bus.rst_core_n & ~bus.rst_fast_n, 8'd0);
            chk("inv_ready_eq_core",     bus.ready ^ bus.rst_core_n,       8'd0);
            chk("inv_pllrst_domains",    bus.pll_rst & (bus.rst_fast_n | bus.rst_core_n), 8'd0);
        end
    end

    task automatic cyc(input logic r, input logic l);
        @(negedge clk);
        rstn           = r;
        bus.pll_locked = l;
    endtask

    logic lv;
    int   left;

    initial begin
        bus.pll_locked = 1'b1;

        // Constant lock: PLL reset falls at edge 3, fast at 11, core at 15.
        repeat (3) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b1, 1'b1);
            chk("seq_pll_rst",    bus.pll_rst,    8'(k < 3));
            chk("seq_rst_fast_n", bus.rst_fast_n, 8'(k >= 11));
            chk("seq_rst_core_n", bus.rst_core_n, 8'(k >= 15));
        end

        // Single-cycle lock drops while running.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0);
            repeat (30) cyc(1'b1, 1'b1);
        end

        // One-cycle reset while running.
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        chk("midrst_pll_rst",  bus.pll_rst,       8'd1);
        chk("midrst_core",     bus.rst_core_n,    8'd0);
        chk("midrst_fast",     bus.rst_fast_n,    8'd0);
        chk("midrst_loss_cnt", bus.lock_loss_cnt, 8'd0);
        repeat (30) cyc(1'b1, 1'b1);

        // Lock toggling every 5 cycles: never stable, repeated timeouts.
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 200; i++) cyc(1'b1, 1'(((i / 5) % 2) == 0));
        chk("timeout_err_set", bus.timeout_err, 8'd1);
        chk("toggle_no_release", bus.rst_fast_n, 8'd0);
        repeat (30) cyc(1'b1, 1'b1);
        chk("timeout_err_sticky", bus.timeout_err, 8'd1);

        // Random lock run lengths with rare resets.
        lv   = 1'b1;
        left = 0;
        for (int i = 0; i < 2000; i++) begin
            if (left == 0) begin
                lv   = ~lv;
                left = lv ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 3));
            end
            left--;
            cyc(1'($urandom_range(0, 299) != 0), lv);
        end

        // Forced losses; the period puts each drop on the REL_FAST->RUN edge.
        cyc(1'b0, 1'b1);
        for (int i = 0; i < 320; i++) begin
            repeat (11) cyc(1'b1, 1'b1);
            cyc(1'b1, 1'b0);
        end
        repeat (30) cyc(1'b1, 1'b1);
        chk("loss_cnt_saturated", bus.lock_loss_cnt, 8'd255);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
